// File: rtl/bus_pkg.sv
// Shared types for the Manta bus initiator: default widths, bus snapshot struct, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bus_pkg;

  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DATA_WIDTH_DEF = 16;

  // One beat on the core-chain bus at default widths.
  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] wdata;
    logic [DATA_WIDTH_DEF-1:0] rdata;
    logic                      rw;
    logic                      valid;
  } bus_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/bus_initiator_if.sv
// Signal bundle between host decoder, bus initiator and core chain.
// Latency: n/a (wires only).
// Backpressure: req valid/ready and resp valid/ready; the chain bus has none.
// Ports: req_* (request in), resp_* (response out), *_o chain input bus,
//        *_i chain output bus, stray_o unsolicited-return pulse.
interface bus_initiator_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  // Host request channel
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic                  req_rw_i;
  logic                  req_valid_i;
  logic                  req_ready_o;
  // Host response channel
  logic [DATA_WIDTH-1:0] resp_rdata_o;
  logic                  resp_rw_o;
  logic                  resp_timeout_o;
  logic                  resp_valid_o;
  logic                  resp_ready_i;
  // Bus into the first core
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [DATA_WIDTH-1:0] wdata_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  rw_o;
  logic                  valid_o;
  // Bus from the last core
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic [DATA_WIDTH-1:0] rdata_i;
  logic                  rw_i;
  logic                  valid_i;
  // Diagnostics
  logic                  stray_o;

  modport master (
    input  req_addr_i, req_wdata_i, req_rw_i, req_valid_i, resp_ready_i,
    input  addr_i, wdata_i, rdata_i, rw_i, valid_i,
    output req_ready_o, resp_rdata_o, resp_rw_o, resp_timeout_o, resp_valid_o,
    output addr_o, wdata_o, rdata_o, rw_o, valid_o, stray_o
  );

  modport slave (
    output req_addr_i, req_wdata_i, req_rw_i, req_valid_i, resp_ready_i,
    output addr_i, wdata_i, rdata_i, rw_i, valid_i,
    input  req_ready_o, resp_rdata_o, resp_rw_o, resp_timeout_o, resp_valid_o,
    input  addr_o, wdata_o, rdata_o, rw_o, valid_o, stray_o
  );

endinterface

// File: rtl/bus_initiator_timeout_counter.sv
// Saturating wait-cycle counter; expired_o is high while the count equals TIMEOUT-1.
// Latency: count updates one cycle after enable; expired_o decodes the register directly.
// Backpressure: none; clear_i has priority over enable_i.
// Ports: clk, rst_n, clear_i (zero the count), enable_i (count up), expired_o.
module timeout_counter #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

  // Stops at TIMEOUT-1 so the count never wraps back to a non-expired value.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_initiator.sv
// Front-end master for the Manta core chain: one request in flight, driven as a one-cycle
// bus beat, matched on return (addr+rw), answered with rdata or a timeout flag.
// Latency: resp_valid_o rises 2 cycles after the chain returns valid_i (N+3 for loopback).
// Backpressure: req_ready_o low from acceptance until the response handshake completes;
//               resp_* held stable until resp_ready_i is sampled high.
// Ports: clk, rst_n, bif (bus_initiator_if.master: request, response, chain in/out, stray).
module bus_initiator
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TIMEOUT    = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  bus_initiator_if.master bif
);

  state_t state_q;

  // Latched request
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rw_q;

  // Returning bus, registered before it is examined
  logic [ADDR_WIDTH-1:0] in_addr_q;
  logic [DATA_WIDTH-1:0] in_rdata_q;
  logic                  in_rw_q;
  logic                  in_valid_q;

  // Registered outputs
  logic                  req_ready_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic                  resp_rw_q;
  logic                  resp_timeout_q;
  logic                  resp_valid_q;
  logic [ADDR_WIDTH-1:0] bus_addr_q;
  logic [DATA_WIDTH-1:0] bus_wdata_q;
  logic                  bus_rw_q;
  logic                  bus_valid_q;
  logic                  stray_q;

  logic match;
  logic expired;
  logic unused_wdata;

  // Write data coming back from the chain carries no information for the host.
  assign unused_wdata = ^bif.wdata_i;

  assign match = in_valid_q && (in_addr_q == addr_q) && (in_rw_q == rw_q);

  timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (state_q == ISSUE),
    .enable_i (state_q == WAIT),
    .expired_o(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      rw_q           <= 1'b0;
      in_addr_q      <= '0;
      in_rdata_q     <= '0;
      in_rw_q        <= 1'b0;
      in_valid_q     <= 1'b0;
      req_ready_q    <= 1'b0;
      resp_rdata_q   <= '0;
      resp_rw_q      <= 1'b0;
      resp_timeout_q <= 1'b0;
      resp_valid_q   <= 1'b0;
      bus_addr_q     <= '0;
      bus_wdata_q    <= '0;
      bus_rw_q       <= 1'b0;
      bus_valid_q    <= 1'b0;
      stray_q        <= 1'b0;
    end else begin
      // Bus beat defaults to all-zero; only the IDLE->ISSUE edge loads it.
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_rw_q    <= 1'b0;
      bus_valid_q <= 1'b0;

      in_addr_q  <= bif.addr_i;
      in_rdata_q <= bif.rdata_i;
      in_rw_q    <= bif.rw_i;
      in_valid_q <= bif.valid_i;

      // Any returned beat that does not complete the outstanding transaction.
      stray_q <= in_valid_q && !((state_q == WAIT) && match);

      case (state_q)
        IDLE: begin
          if (bif.req_valid_i && req_ready_q) begin
            addr_q      <= bif.req_addr_i;
            wdata_q     <= bif.req_wdata_i;
            rw_q        <= bif.req_rw_i;
            bus_addr_q  <= bif.req_addr_i;
            bus_wdata_q <= bif.req_wdata_i;
            bus_rw_q    <= bif.req_rw_i;
            bus_valid_q <= 1'b1;
            req_ready_q <= 1'b0;
            state_q     <= ISSUE;
          end else begin
            req_ready_q <= 1'b1;
          end
        end

        ISSUE: begin
          state_q <= WAIT;
        end

        WAIT: begin
          // Match is tested first so a return on the last allowed cycle still completes.
          if (match) begin
            resp_rdata_q   <= rw_q ? '0 : in_rdata_q;
            resp_rw_q      <= rw_q;
            resp_timeout_q <= 1'b0;
            resp_valid_q   <= 1'b1;
            state_q        <= RESP;
          end else if (expired) begin
            resp_rdata_q   <= '0;
            resp_rw_q      <= rw_q;
            resp_timeout_q <= 1'b1;
            resp_valid_q   <= 1'b1;
            state_q        <= RESP;
          end
        end

        RESP: begin
          if (bif.resp_ready_i) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bif.req_ready_o    = req_ready_q;
  assign bif.resp_rdata_o   = resp_rdata_q;
  assign bif.resp_rw_o      = resp_rw_q;
  assign bif.resp_timeout_o = resp_timeout_q;
  assign bif.resp_valid_o   = resp_valid_q;
  assign bif.addr_o         = bus_addr_q;
  assign bif.wdata_o        = bus_wdata_q;
  assign bif.rw_o           = bus_rw_q;
  assign bif.valid_o        = bus_valid_q;
  assign bif.stray_o        = stray_q;
  // The initiator never supplies read data into the chain.
  assign bif.rdata_o        = '0;

endmodule

// File: tb/tb_bus_initiator.sv
// Self-checking bench for bus_initiator with a cycle-level chain model driven from one initial block.
// Latency: expectations derived from return delay d: response at d+2 after the issue beat, or TIMEOUT+1.
// Backpressure: randomized resp_ready_i outside RESP, directed hold inside RESP.
module tb_bus_initiator;
  import bus_pkg::*;

  localparam int TO = 8;
  localparam int W  = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bus_initiator_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bif ();

  bus_initiator #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (16),
    .TIMEOUT    (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bif   (bif)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction. d = cycles from the issue beat to the chain return (<0: never returns).
  // bad_s = cycle of an injected mismatching return (<0: none). hold = cycles resp_ready_i stays low.
  task automatic do_txn(input string nm, input logic [15:0] a, input logic [15:0] wd,
                        input logic rw, input int d, input logic [15:0] rd,
                        input int hold, input int bad_s);
    bus_t        snap;
    int          vo_cnt, junk, t_resp, unstable, rdy_bad, stray_cnt, hs, w;
    logic [15:0] r_rd;
    logic        r_rw, r_to, post_vld, post_rdy;
    logic        to_exp;
    int          t_resp_exp, stray_exp;
    logic [15:0] rd_exp;

    snap = '0; vo_cnt = 0; junk = 0; t_resp = -1; unstable = 0; rdy_bad = 0;
    stray_cnt = 0; hs = -1; r_rd = '0; r_rw = 1'b0; r_to = 1'b0;
    post_vld = 1'bx; post_rdy = 1'bx;

    // Reference rules
    to_exp     = (d < 0) || (d > TO - 1);
    t_resp_exp = to_exp ? TO + 1 : d + 2;
    rd_exp     = (to_exp || rw) ? 16'h0 : rd;
    stray_exp  = ((bad_s >= 0) ? 1 : 0) + ((d > TO - 1) ? 1 : 0);

    w = 0;
    while (bif.req_ready_o !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("%s.req_ready", nm), 32'(bif.req_ready_o), 32'd1);

    bif.req_addr_i  = a;
    bif.req_wdata_i = wd;
    bif.req_rw_i    = rw;
    bif.req_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);

    for (int t = 0; t < W; t++) begin
      // Observe cycle t
      if (t == 0) begin
        snap = '{addr: bif.addr_o, wdata: bif.wdata_o, rdata: bif.rdata_o,
                 rw: bif.rw_o, valid: bif.valid_o};
      end else if ((bif.addr_o | bif.wdata_o | bif.rdata_o) != 16'h0 || bif.rw_o || bif.valid_o) begin
        junk++;
      end
      if (bif.valid_o === 1'b1) vo_cnt++;
      if (bif.stray_o === 1'b1) stray_cnt++;
      if (hs >= 0 && t == hs + 1) begin
        post_vld = bif.resp_valid_o;
        post_rdy = bif.req_ready_o;
      end
      if (t_resp < 0 && hs < 0 && bif.resp_valid_o === 1'b1) begin
        t_resp = t;
        r_rd   = bif.resp_rdata_o;
        r_rw   = bif.resp_rw_o;
        r_to   = bif.resp_timeout_o;
      end else if (t_resp >= 0 && hs < 0) begin
        if (bif.resp_valid_o !== 1'b1 || bif.resp_rdata_o !== r_rd ||
            bif.resp_rw_o !== r_rw || bif.resp_timeout_o !== r_to) unstable++;
      end
      if (t_resp >= 0 && hs < 0 && bif.req_ready_o !== 1'b0) rdy_bad++;

      // Drive cycle t
      if (t_resp >= 0 && hs < 0) begin
        bif.resp_ready_i = (t == t_resp + hold);
        if (t == t_resp + hold) hs = t;
      end else begin
        bif.resp_ready_i = 1'($urandom_range(0, 1));
      end
      bif.req_valid_i = (hs < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      bif.req_addr_i  = 16'($urandom);
      bif.req_wdata_i = 16'($urandom);
      bif.req_rw_i    = 1'($urandom_range(0, 1));

      bif.addr_i  = a;
      bif.rw_i    = rw;
      bif.wdata_i = wd;
      bif.rdata_i = 16'($urandom);
      bif.valid_i = 1'b0;
      if (t == d) begin
        bif.rdata_i = rd;
        bif.valid_i = 1'b1;
      end else if (t == bad_s) begin
        bif.addr_i  = a ^ 16'h0001;
        bif.valid_i = 1'b1;
      end

      @(posedge clk);
      @(negedge clk);
    end

    bif.valid_i      = 1'b0;
    bif.resp_ready_i = 1'b0;
    bif.req_valid_i  = 1'b0;

    chk($sformatf("%s.issue_valid", nm), 32'(snap.valid), 32'd1);
    chk($sformatf("%s.issue_addr", nm),  32'(snap.addr),  32'(a));
    chk($sformatf("%s.issue_wdata", nm), 32'(snap.wdata), 32'(wd));
    chk($sformatf("%s.issue_rw", nm),    32'(snap.rw),    32'(rw));
    chk($sformatf("%s.issue_rdata", nm), 32'(snap.rdata), 32'd0);
    chk($sformatf("%s.valid_pulses", nm), 32'(vo_cnt), 32'd1);
    chk($sformatf("%s.bus_idle_zero", nm), 32'(junk), 32'd0);
    chk($sformatf("%s.resp_time", nm), 32'(t_resp), 32'(t_resp_exp));
    chk($sformatf("%s.resp_rdata", nm), 32'(r_rd), 32'(rd_exp));
    chk($sformatf("%s.resp_rw", nm), 32'(r_rw), 32'(rw));
    chk($sformatf("%s.resp_timeout", nm), 32'(r_to), 32'(to_exp));
    chk($sformatf("%s.resp_stable", nm), 32'(unstable), 32'd0);
    chk($sformatf("%s.ready_low_in_resp", nm), 32'(rdy_bad), 32'd0);
    chk($sformatf("%s.handshake_seen", nm), 32'(hs >= 0), 32'd1);
    chk($sformatf("%s.post_resp_valid", nm), 32'(post_vld), 32'd0);
    chk($sformatf("%s.post_req_ready", nm), 32'(post_rdy), 32'd1);
    chk($sformatf("%s.stray_pulses", nm), 32'(stray_cnt), 32'(stray_exp));
  endtask

  initial begin
    int d, bad, w;

    bif.req_addr_i   = '0;
    bif.req_wdata_i  = '0;
    bif.req_rw_i     = 1'b0;
    bif.req_valid_i  = 1'b0;
    bif.resp_ready_i = 1'b0;
    bif.addr_i       = '0;
    bif.wdata_i      = '0;
    bif.rdata_i      = '0;
    bif.rw_i         = 1'b0;
    bif.valid_i      = 1'b0;

    // Reset state
    #12;
    chk("reset_flags", 32'({bif.req_ready_o, bif.valid_o, bif.rw_o, bif.resp_valid_o,
                            bif.resp_timeout_o, bif.resp_rw_o, bif.stray_o}), 32'd0);
    chk("reset_data", 32'(bif.addr_o | bif.wdata_o | bif.rdata_o | bif.resp_rdata_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_release_ready", 32'(bif.req_ready_o), 32'd1);

    // Directed cases
    do_txn("rd_beef",      16'h0000, 16'h5555, 1'b0, 3,  16'hBEEF, 0, -1);
    do_txn("wr_1234",      16'h0003, 16'h1234, 1'b1, 0,  16'hA5A5, 0, -1);
    do_txn("timeout_late", 16'h0040, 16'h0000, 1'b0, 10, 16'h7777, 5, -1);
    do_txn("timeout_none", 16'h0041, 16'h0101, 1'b1, -1, 16'h0000, 1, -1);
    do_txn("mismatch",     16'h0004, 16'h0000, 1'b0, 4,  16'hC0DE, 0, 1);
    do_txn("hold5",        16'h0010, 16'h0000, 1'b0, 2,  16'h1111, 5, -1);
    do_txn("b2b_read",     16'h0011, 16'h0000, 1'b0, 1,  16'h2222, 0, -1);
    do_txn("edge_d7",      16'h0012, 16'h0000, 1'b0, 7,  16'h3333, 0, -1);
    do_txn("edge_d8",      16'h0013, 16'h0000, 1'b0, 8,  16'h4444, 2, -1);

    // Randomized transactions
    for (int i = 0; i < 20; i++) begin
      d = int'($urandom_range(0, 11));
      if (d == 11) d = -1;
      bad = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, W - 3)) : -1;
      if (bad == d) bad = -1;
      do_txn($sformatf("rand%0d", i), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
             d, 16'($urandom), int'($urandom_range(0, 3)), bad);
    end

    // Reset while waiting for a return
    w = 0;
    while (bif.req_ready_o !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("midwait.req_ready", 32'(bif.req_ready_o), 32'd1);
    bif.req_addr_i  = 16'h00AA;
    bif.req_wdata_i = 16'h0000;
    bif.req_rw_i    = 1'b0;
    bif.req_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bif.req_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midwait.reset_flags", 32'({bif.req_ready_o, bif.valid_o, bif.rw_o, bif.resp_valid_o,
                                    bif.resp_timeout_o, bif.resp_rw_o, bif.stray_o}), 32'd0);
    chk("midwait.reset_data", 32'(bif.addr_o | bif.wdata_o | bif.rdata_o | bif.resp_rdata_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midwait.release_ready", 32'(bif.req_ready_o), 32'd1);
    do_txn("post_reset", 16'h0020, 16'h0000, 1'b0, 3, 16'h3C3C, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
